// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader that fills instruction memory and holds the core in reset until done.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
//   state  | meaning
//   IDLE   | waiting for sync byte 0xA5
//   LEN_LO | expecting word count, low byte
//   LEN_HI | expecting word count, high byte
//   DATA   | collecting word bytes, writing each completed word
//   CHK    | expecting checksum byte (checksum build only)
//   DONE   | image loaded, core released
//   ERR    | frame rejected, core held
`timescale 1ns/1ps
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CHK;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  // ---------------- UART receiver ----------------
  logic [2:0]    rx_sync_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_s, rx_prev;

  assign rx_s    = rx_sync_q[1];
  assign rx_prev = rx_sync_q[2];

  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_state_d = RX_START;
        cnt_d      = CW'(CLKS_PER_BIT / 2 - 1);
      end
      RX_START: if (cnt_q == '0) begin
        if (rx_s) rx_state_d = RX_IDLE;
        else begin
          rx_state_d = RX_DATA;
          cnt_d      = CW'(CLKS_PER_BIT - 1);
          bit_d      = 3'd0;
        end
      end else cnt_d = cnt_q - CW'(1);
      RX_DATA: if (cnt_q == '0) begin
        sh_d  = {rx_s, sh_q[7:1]};
        cnt_d = CW'(CLKS_PER_BIT - 1);
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_state_d = RX_STOP;
      end else cnt_d = cnt_q - CW'(1);
      RX_STOP: if (cnt_q == '0) begin
        rx_valid_d  = rx_s;
        frame_err_d = !rx_s;
        rx_state_d  = RX_IDLE;
      end else cnt_d = cnt_q - CW'(1);
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- frame loader ----------------
  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           word_q, word_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  release_q, release_d;
  logic                  err_q, err_d;
  logic [15:0]           n_full;
  logic                  in_frame;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign n_full = {sh_q, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    in_frame = state_q inside {LEN_LO, LEN_HI, DATA, CHK};
    if (rx_valid_q && state_q inside {LEN_LO, LEN_HI, DATA}) csum_d = csum_q ^ sh_q;
`else
    in_frame = state_q inside {LEN_LO, LEN_HI, DATA};
`endif
    if (rx_valid_q) begin
      case (state_q)
        IDLE, DONE, ERR: if (sh_q == 8'hA5) begin
          state_d = LEN_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
        LEN_LO: begin
          len_d[7:0] = sh_q;
          state_d    = LEN_HI;
        end
        LEN_HI: begin
          len_d[15:8] = sh_q;
          idx_d       = '0;
          lane_d      = 2'd0;
          if (n_full == 16'd0) state_d = AFTER_LAST;
          else if (32'(n_full) > (32'd1 << ADDR_WIDTH)) state_d = ERR;
          else state_d = DATA;
        end
        DATA: begin
          word_d = {sh_q, word_q[31:8]};
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = word_d;
            if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = AFTER_LAST;
            else idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: state_d = (sh_q == csum_q) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
    if (frame_err_q && in_frame) state_d = ERR;
  end

  // Release waits one cycle past the final write so the core never runs while we is high.
  always_comb begin
    release_d = (state_d == DONE) && !we_d;
    err_d     = (state_d == ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
    busy_d    = (state_d inside {LEN_LO, LEN_HI, DATA, CHK}) || we_d;
`else
    busy_d    = (state_d inside {LEN_LO, LEN_HI, DATA}) || we_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_q   <= 3'b111;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      sh_q        <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= IDLE;
      len_q       <= 16'h0000;
      idx_q       <= '0;
      lane_q      <= 2'd0;
      word_q      <= 32'h0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      release_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      rx_sync_q   <= {rx_sync_q[1:0], uart_rx};
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      release_q   <= release_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset_n = release_q;
  assign done        = release_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: expected writes are queued at stimulus time, a monitor pops them on each imem_we.
`timescale 1ns/1ps
module tb_imem_uart_loader;
  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset_n, busy, done, err;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  logic prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write must be expected, single-cycle, and happen while the core is held.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_t w;
      check("we_single_cycle", prev_we, 1'b0);
      check("cpu_held_during_write", cpu_reset_n, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        w = exp_q.pop_front();
        check("write_addr", imem_addr, w.addr);
        check("write_data", imem_wdata, w.data);
      end
    end
    prev_we = imem_we;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b0);
    repeat (10) @(posedge clk);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic check_status(input string name, input logic c, input logic dn, input logic e, input logic b);
    @(negedge clk);
    check({name, ".cpu_reset_n"}, cpu_reset_n, c);
    check({name, ".done"}, done, dn);
    check({name, ".err"}, err, e);
    check({name, ".busy"}, busy, b);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".we"}, imem_we, 1'b0);
    check({name, ".addr"}, imem_addr, '0);
    check({name, ".wdata"}, imem_wdata, 32'h0);
    check({name, ".cpu_reset_n"}, cpu_reset_n, 1'b0);
    check({name, ".busy"}, busy, 1'b0);
    check({name, ".done"}, done, 1'b0);
    check({name, ".err"}, err, 1'b0);
  endtask

  task automatic basic_frame();
    logic [7:0] f[$];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(8'hA2);
`endif
    expect_wr(4'd0, 32'h0000_0013);
    expect_wr(4'd1, 32'h0000_00B3);
    send_frame(f);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] cs;
    logic [31:0] w;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Noise bytes and a one-cycle glitch are ignored
    f = '{8'h00, 8'hFF, 8'h3C};
    send_frame(f);
    @(posedge clk); uart_rx = 1'b0;
    @(posedge clk); uart_rx = 1'b1;
    repeat (15) @(posedge clk);
    check_status("noise", 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic load
    basic_frame();
    check_status("basic", 1'b1, 1'b1, 1'b0, 1'b0);
    check("basic_drained", exp_q.size(), 0);

    // Reload from DONE: sync byte re-holds the core
    send_byte(8'hA5, 1'b0);
    repeat (3) @(posedge clk);
    check_status("reload_sync", 1'b0, 1'b0, 1'b0, 1'b1);
    f = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(8'h23);
`endif
    expect_wr(4'd0, 32'hDEAD_BEEF);
    send_frame(f);
    check_status("reload", 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: word still written, core stays held
    f = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    expect_wr(4'd0, 32'h1234_5678);
    send_frame(f);
    check_status("bad_checksum", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Oversized count
    f = '{8'hA5, 8'h11, 8'h00};
    send_frame(f);
    check_status("oversized", 1'b0, 1'b0, 1'b1, 1'b0);

    // Zero-length image releases the core directly
    f = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    send_frame(f);
    check_status("zero_len", 1'b1, 1'b1, 1'b0, 1'b0);

    // Framing error on 3rd data byte: no partial write
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    foreach (f[i]) send_byte(f[i], 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (10) @(posedge clk);
    check_status("framing", 1'b0, 1'b0, 1'b1, 1'b0);
    basic_frame();
    check_status("after_framing", 1'b1, 1'b1, 1'b0, 1'b0);

    // Full capacity: N = 2^AW
    f = '{8'hA5, 8'h10, 8'h00};
    cs = 8'h10;
    for (int i = 0; i < 16; i++) begin
      w = {24'hC0FFEE, 8'(i)};
      expect_wr(AW'(i), w);
      for (int k = 0; k < 4; k++) begin
        f.push_back(w[8*k +: 8]);
        cs ^= w[8*k +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(cs);
`endif
    send_frame(f);
    check_status("full", 1'b1, 1'b1, 1'b0, 1'b0);
    check("full_last_addr", imem_addr, 4'hF);
    check("full_drained", exp_q.size(), 0);

    // Reset mid-frame after two data bytes
    f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    foreach (f[i]) send_byte(f[i], 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    check_status("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
